rr_arb8_enc: RTL and testbench
==============================

Name: rr_arb8_enc

Overview:
- Registered 8-way round-robin arbiter.
- Samples 8 request lines and grants one requester at a time.
- Presents the winner as a 3-bit index plus a valid/enable bit, which drives the downstream 3-to-8 structural decoder; the decoder produces the one-hot grant lines.
- Holds each grant until the requester releases, signals done, or exceeds a hold limit.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one grant may stay valid. Legal range 1..255.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on rising clk.
- req  input  8  request lines; req[k]=1 means requester k wants the resource.
- done  input  1  release strobe from the current owner; meaningful only while gnt_vld=1.
- gnt_idx  output  3  index of the current owner; drives decoder select i.
- gnt_vld  output  1  grant valid; drives decoder enable e.
- timeout  output  1  one-cycle pulse on the cycle after a forced release.
- ptr  output  3  current round-robin priority pointer, for debug and verification.

Behaviour:
- Interface rule: one clock, `clk`. Reset `rst_n` is synchronous and active-low. No asynchronous reset path.
- Reset when rst_n=0 at a rising edge:
  - state=IDLE
  - gnt_idx=3'd0, gnt_vld=0, timeout=0
  - ptr=3'd0, hold counter=0
  - Applies from any state, including mid-grant: gnt_vld is 0 after that edge.
- All outputs are registered; no combinational path from req or done to any output.
- State IDLE:
  - gnt_vld=0.
  - If req!=0 at a rising edge: select winner w = first k with req[k]=1, searching ptr, ptr+1, ..., ptr+7 (mod 8).
  - Load gnt_idx=w, gnt_vld=1, hold counter=1, move to GRANT.
  - Latency: request sampled at edge N gives gnt_vld=1 immediately after edge N.
  - If req==0: stay in IDLE; gnt_idx keeps its last value.
- State GRANT:
  - gnt_idx is stable; gnt_vld=1.
  - At each rising edge, evaluate release conditions in this priority order:
    1. done=1, or req[gnt_idx]=0: normal release, timeout=0.
    2. Hold counter==MAX_HOLD: forced release, timeout=1 for exactly one cycle.
    3. Otherwise: hold counter increments and the state stays GRANT.
  - On any release: gnt_vld=0, ptr=gnt_idx+1 (mod 8, 3'd7 wraps to 3'd0), state=IDLE.
  - Hold counter saturates at MAX_HOLD.
- Re-arbitration:
  - At least one idle cycle (gnt_vld=0) separates consecutive grants. This bubble is mandatory so the decoder outputs are never two-hot across a switch.
- Count rule: a grant holds gnt_vld=1 for exactly min(release cycle, MAX_HOLD) cycles.
  - MAX_HOLD=1 gives a one-cycle grant with timeout asserted whenever done=0 and the request persists.
- Boundary and simultaneous-event cases:
  - done=1 and hold counter==MAX_HOLD in the same cycle: normal release, timeout=0.
  - done asserted while in IDLE: ignored.
  - req changes on non-owner lines during GRANT: ignored until the next arbitration.
  - Owner drops its request and raises done in the same cycle: single normal release.
  - A timed-out requester that still requests loses priority to all others because ptr has advanced past it. It is re-granted only when no other k in the search order requests.
- ptr changes only on release or reset.
- timeout is 0 in every cycle other than the one following a forced release.

Test Plan:
- Reset then single request: rst_n=0 for 2 cycles, then req=8'h04 -> next edge gnt_idx=2, gnt_vld=1; deassert req -> gnt_vld=0 next edge, ptr=3.
- Round-robin fairness: req=8'hFF held, done pulsed once per grant -> grant order 0,1,2,...,7,0, with one gnt_vld=0 cycle between each grant; ptr wraps 7->0.
- Pointer skip: ptr=3 (after a grant to 2), req=8'h05 -> winner 0 (3..7 idle, wraps), not 2; then ptr=1 after release.
- Timeout, MAX_HOLD=16: req=8'h80 held, done=0 -> gnt_vld high exactly 16 cycles, timeout=1 for exactly 1 cycle, ptr=0. With req still 8'h80 after the idle cycle -> idx 7 is re-granted.
- Simultaneous done and limit: on cycle 16 of a grant, done=1 -> release with timeout=0.
- Reset mid-grant: grant active on idx 5 at hold=7, rst_n=0 for one edge -> gnt_vld=0, gnt_idx=0, ptr=0, timeout=0. With req=8'h20 still high after release of reset -> re-granted to 5 one edge later.

Source files
------------

// File: rtl/rr_arb8_enc_if.sv
// Request/grant bundle between eight requesters and the round-robin arbiter.
// The arbiter sits on the slave side, and the requesters or the bench sit on the master side.
interface rr_arb8_enc_if;
  logic [7:0] req;
  logic       done;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;
  logic [2:0] ptr;

  modport master (output req, done, input gnt_idx, gnt_vld, timeout, ptr);
  modport slave  (input req, done, output gnt_idx, gnt_vld, timeout, ptr);
endinterface

// File: rtl/rr_arb8_enc.sv
// Registered 8-way round-robin arbiter with a hold limit.
// It emits an encoded winner index and an enable bit for a downstream 3-to-8 decoder.
module rr_arb8_enc #(
  parameter int MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_arb8_enc_if.slave  bus
);
  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] ptr_q, ptr_d;
  logic       vld_q, vld_d;
  logic       to_q, to_d;
  logic [7:0] hold_q, hold_d;
  logic [2:0] win;
  logic       rel;

  // First requester at or after ptr. The loop scans downward, so the nearest match is written last and wins.
  always_comb begin
    win = ptr_q;
    for (int i = 7; i >= 0; i--)
      if (bus.req[ptr_q + 3'(i)]) win = ptr_q + 3'(i);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    vld_d   = vld_q;
    to_d    = 1'b0;
    hold_d  = hold_q;
    rel     = 1'b0;
    case (state_q)
      IDLE: begin
        vld_d = 1'b0;
        if (|bus.req) begin
          idx_d   = win;
          vld_d   = 1'b1;
          hold_d  = 8'd1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // A normal release takes priority over the hold limit, so done at the limit does not time out.
        if (bus.done || !bus.req[idx_q]) begin
          rel = 1'b1;
        end else if (hold_q == 8'(MAX_HOLD)) begin
          rel  = 1'b1;
          to_d = 1'b1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
        if (rel) begin
          vld_d   = 1'b0;
          ptr_d   = idx_q + 3'd1;
          hold_d  = 8'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      ptr_q   <= 3'd0;
      vld_q   <= 1'b0;
      to_q    <= 1'b0;
      hold_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      vld_q   <= vld_d;
      to_q    <= to_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.gnt_idx = idx_q;
  assign bus.gnt_vld = vld_q;
  assign bus.timeout = to_q;
  assign bus.ptr     = ptr_q;
endmodule

// File: tb/tb_rr_arb8_enc.sv
// Directed bench for rr_arb8_enc: a cycle-level reference model is compared on every cycle.
// Literal expectations taken from the stimulus plan are checked as well.
module tb_rr_arb8_enc;
  localparam int MAX_HOLD = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  bit   cmp_en = 1'b0;

  rr_arb8_enc_if bus();

  rr_arb8_enc #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: ownership, cycles held, and the next search start.
  int m_idx = 0, m_ptr = 0, m_age = 0, m_w;
  bit m_vld = 1'b0, m_to = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_idx = 0; m_ptr = 0; m_age = 0; m_vld = 1'b0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (!m_vld) begin
        m_w = -1;
        for (int k = 0; k < 8; k++)
          if (m_w < 0 && bus.req[(m_ptr + k) % 8]) m_w = (m_ptr + k) % 8;
        if (m_w >= 0) begin
          m_idx = m_w; m_vld = 1'b1; m_age = 1;
        end
      end else if (bus.done || !bus.req[m_idx]) begin
        m_vld = 1'b0; m_ptr = (m_idx + 1) % 8;
      end else if (m_age >= MAX_HOLD) begin
        m_vld = 1'b0; m_to = 1'b1; m_ptr = (m_idx + 1) % 8;
      end else begin
        m_age++;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_vld", int'(bus.gnt_vld), int'(m_vld));
      chk("model_idx", int'(bus.gnt_idx), m_idx);
      chk("model_timeout", int'(bus.timeout), int'(m_to));
      chk("model_ptr", int'(bus.ptr), m_ptr);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus.req = 8'h00;
    bus.done = 1'b0;

    // Reset, then a single request.
    cyc(2);
    cmp_en = 1'b1;
    chk("rst_vld", int'(bus.gnt_vld), 0);
    chk("rst_idx", int'(bus.gnt_idx), 0);
    chk("rst_ptr", int'(bus.ptr), 0);
    chk("rst_timeout", int'(bus.timeout), 0);
    rst_n = 1'b1;
    bus.req = 8'h04;
    cyc(1);
    chk("single_idx", int'(bus.gnt_idx), 2);
    chk("single_vld", int'(bus.gnt_vld), 1);
    bus.req = 8'h00;
    cyc(1);
    chk("single_rel_vld", int'(bus.gnt_vld), 0);
    chk("single_rel_ptr", int'(bus.ptr), 3);

    // Pointer skip: with ptr at 3, requests 0 and 2 resolve to 0.
    bus.req = 8'h05;
    cyc(1);
    chk("skip_idx", int'(bus.gnt_idx), 0);
    bus.done = 1'b1;
    cyc(1);
    chk("skip_ptr", int'(bus.ptr), 1);
    bus.done = 1'b0;
    bus.req = 8'h00;
    cyc(1);

    // Round-robin fairness from ptr 0 with all lines requesting.
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    bus.req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      cyc(1);
      chk("rr_idx", int'(bus.gnt_idx), k % 8);
      chk("rr_vld", int'(bus.gnt_vld), 1);
      bus.done = 1'b1;
      cyc(1);
      chk("rr_bubble", int'(bus.gnt_vld), 0);
      chk("rr_ptr", int'(bus.ptr), (k + 1) % 8);
      bus.done = 1'b0;
    end
    bus.req = 8'h00;
    cyc(1);

    // Hold limit: 16 valid cycles, then a single timeout pulse.
    bus.req = 8'h80;
    cyc(1);
    for (int i = 0; i < MAX_HOLD; i++) begin
      chk("to_hold_vld", int'(bus.gnt_vld), 1);
      chk("to_hold_pulse", int'(bus.timeout), 0);
      cyc(1);
    end
    chk("to_vld", int'(bus.gnt_vld), 0);
    chk("to_pulse", int'(bus.timeout), 1);
    chk("to_ptr", int'(bus.ptr), 0);
    cyc(1);
    chk("to_regrant_idx", int'(bus.gnt_idx), 7);
    chk("to_regrant_vld", int'(bus.gnt_vld), 1);
    chk("to_pulse_clear", int'(bus.timeout), 0);

    // done on the same edge the hold limit is reached counts as a normal release.
    cyc(MAX_HOLD - 1);
    bus.done = 1'b1;
    cyc(1);
    chk("sim_vld", int'(bus.gnt_vld), 0);
    chk("sim_timeout", int'(bus.timeout), 0);
    bus.done = 1'b0;
    bus.req = 8'h00;
    cyc(1);

    // done while idle has no effect.
    bus.done = 1'b1;
    cyc(2);
    chk("idle_done_vld", int'(bus.gnt_vld), 0);
    bus.done = 1'b0;

    // Reset in the middle of a grant held for 7 cycles.
    bus.req = 8'h20;
    cyc(7);
    rst_n = 1'b0;
    cyc(1);
    chk("midrst_vld", int'(bus.gnt_vld), 0);
    chk("midrst_idx", int'(bus.gnt_idx), 0);
    chk("midrst_ptr", int'(bus.ptr), 0);
    chk("midrst_timeout", int'(bus.timeout), 0);
    rst_n = 1'b1;
    cyc(1);
    chk("midrst_regrant", int'(bus.gnt_idx), 5);
    chk("midrst_regrant_vld", int'(bus.gnt_vld), 1);

    // Other lines changing during a grant are ignored. The owner drops its request and raises done together.
    bus.req = 8'hFF;
    cyc(3);
    chk("nonowner_idx", int'(bus.gnt_idx), 5);
    bus.req = 8'hDF;
    bus.done = 1'b1;
    cyc(1);
    chk("drop_done_vld", int'(bus.gnt_vld), 0);
    chk("drop_done_ptr", int'(bus.ptr), 6);
    chk("drop_done_timeout", int'(bus.timeout), 0);
    bus.done = 1'b0;
    cyc(1);
    chk("after_drop_idx", int'(bus.gnt_idx), 6);
    bus.req = 8'h00;
    cyc(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
